// File: rtl/mem_responder_if.sv
// Request/response handshake bundle between the cache miss path and mem_responder.
`timescale 1ns/1ps
interface mem_responder_if #(
  parameter int ADDRESS_SIZE = 16
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [ADDRESS_SIZE-1:0] req_addr;
  logic                    resp_valid;
  logic                    resp_ready;
  logic                    resp_we;
  logic [ADDRESS_SIZE-1:0] resp_addr;

  // Cache side: issues requests, consumes completions.
  modport master (
    output req_valid, req_we, req_addr, resp_ready,
    input  req_ready, resp_valid, resp_we, resp_addr
  );

  // Memory side: accepts requests, produces completions.
  modport slave (
    input  req_valid, req_we, req_addr, resp_ready,
    output req_ready, resp_valid, resp_we, resp_addr
  );
endinterface

// File: rtl/mem_responder.sv
// Next-level memory model: in-order request FIFO, fixed service latency,
// one completion per request. Tracks line addresses, types and statistics only.
`timescale 1ns/1ps
module mem_responder #(
  parameter int ADDRESS_SIZE = 16,
  parameter int LINESIZE     = 128,
  parameter int LATENCY      = 4,
  parameter int QDEPTH       = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  mem_responder_if.slave          bus,
  output logic [$clog2(QDEPTH):0] q_count,
  output logic [31:0]             num_fills,
  output logic [31:0]             num_writebacks,
  output logic                    busy
);

  localparam int BS = $clog2(LINESIZE >> 3);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [ADDRESS_SIZE-1:0] ALIGN_MASK = ~(ADDRESS_SIZE'((1 << BS) - 1));
  localparam logic [LW-1:0] CNT_LOAD = LW'(LATENCY - 1);
  localparam logic [CW-1:0] FULL     = CW'(QDEPTH);

  if (LATENCY < 1 || QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0) begin : g_bad_params
    $fatal(1, "mem_responder: illegal LATENCY/QDEPTH");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e                  state_q, state_d;
  logic [LW-1:0]           cnt_q, cnt_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    req_ready_q, req_ready_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    resp_we_q, resp_we_d;
  logic [ADDRESS_SIZE-1:0] resp_addr_q, resp_addr_d;
  logic [31:0]             fills_q, fills_d;
  logic [31:0]             wbs_q, wbs_d;

  logic                    fifo_we_q   [QDEPTH];
  logic [ADDRESS_SIZE-1:0] fifo_addr_q [QDEPTH];

  logic push;
  logic pop;
  logic handshake;

  // Next-state for FIFO pointers/occupancy, service FSM and statistics.
  // The response registers double as the service register: they are loaded
  // at pop time and only become visible once resp_valid rises.
  always_comb begin
    push         = bus.req_valid && req_ready_q;
    handshake    = resp_valid_q && bus.resp_ready;
    pop          = 1'b0;
    state_d      = state_q;
    cnt_d        = cnt_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    resp_valid_d = resp_valid_q;
    resp_we_d    = resp_we_q;
    resp_addr_d  = resp_addr_q;
    fills_d      = fills_q;
    wbs_d        = wbs_q;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) pop = 1'b1;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - LW'(1);
        end
      end
      S_RESP: begin
        if (handshake) begin
          resp_valid_d = 1'b0;
          if (resp_we_q) wbs_d   = wbs_q + 32'd1;
          else           fills_d = fills_q + 32'd1;
          if (count_q != '0) pop = 1'b1;
          else               state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      state_d     = S_WAIT;
      cnt_d       = CNT_LOAD;
      resp_we_d   = fifo_we_q[rd_ptr_q];
      resp_addr_d = fifo_addr_q[rd_ptr_q];
      rd_ptr_d    = rd_ptr_q + PW'(1);
    end

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);

    count_d     = count_q + CW'(push) - CW'(pop);
    req_ready_d = (count_d != FULL);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_we_q    <= 1'b0;
      resp_addr_q  <= '0;
      fills_q      <= '0;
      wbs_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_we_q    <= resp_we_d;
      resp_addr_q  <= resp_addr_d;
      fills_q      <= fills_d;
      wbs_q        <= wbs_d;
    end
  end

  // FIFO storage; contents need no reset since the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      fifo_we_q[wr_ptr_q]   <= bus.req_we;
      fifo_addr_q[wr_ptr_q] <= bus.req_addr & ALIGN_MASK;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_we     = resp_we_q;
  assign bus.resp_addr   = resp_addr_q;
  assign q_count         = count_q;
  assign num_fills       = fills_q;
  assign num_writebacks  = wbs_q;
  assign busy            = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (default build plus a
// LATENCY=1 / QDEPTH=2 build).
`timescale 1ns/1ps
module tb_mem_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_responder_if #(.ADDRESS_SIZE(16)) if0 ();
  mem_responder_if #(.ADDRESS_SIZE(16)) if1 ();

  logic [2:0]  q_count0;
  logic [31:0] nf0, nw0;
  logic        busy0;
  logic [1:0]  q_count1;
  logic [31:0] nf1, nw1;
  logic        busy1;

  mem_responder #(.ADDRESS_SIZE(16), .LINESIZE(128), .LATENCY(4), .QDEPTH(4)) u_dut (
    .clk(clk), .reset(reset), .bus(if0), .q_count(q_count0),
    .num_fills(nf0), .num_writebacks(nw0), .busy(busy0)
  );

  mem_responder #(.ADDRESS_SIZE(16), .LINESIZE(128), .LATENCY(1), .QDEPTH(2)) u_dut1 (
    .clk(clk), .reset(reset), .bus(if1), .q_count(q_count1),
    .num_fills(nf1), .num_writebacks(nw1), .busy(busy1)
  );

  int checks = 0;
  int errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    if0.req_valid = 1'b0; if0.req_we = 1'b0; if0.req_addr = '0; if0.resp_ready = 1'b0;
    if1.req_valid = 1'b0; if1.req_we = 1'b0; if1.req_addr = '0; if1.resp_ready = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (if0.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %0h expected 1", if0.req_ready); end
    checks++; if (if0.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %0h expected 0", if0.resp_valid); end
    checks++; if (if0.resp_we !== 1'b0) begin errors++; $display("FAIL reset_resp_we: got %0h expected 0", if0.resp_we); end
    checks++; if (if0.resp_addr !== 16'h0000) begin errors++; $display("FAIL reset_resp_addr: got %0h expected 0", if0.resp_addr); end
    checks++; if (q_count0 !== 3'd0) begin errors++; $display("FAIL reset_q_count: got %0d expected 0", q_count0); end
    checks++; if (nf0 !== 32'd0) begin errors++; $display("FAIL reset_num_fills: got %0d expected 0", nf0); end
    checks++; if (nw0 !== 32'd0) begin errors++; $display("FAIL reset_num_writebacks: got %0d expected 0", nw0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0h expected 0", busy0); end
  endtask

  task automatic test_single_fill();
    int early;
    do_reset();
    if0.resp_ready = 1'b1;
    if0.req_valid = 1'b1; if0.req_we = 1'b0; if0.req_addr = 16'h1234;
    step();                                   // accepted at edge t
    if0.req_valid = 1'b0;
    checks++; if (q_count0 !== 3'd1) begin errors++; $display("FAIL fill_q_count_push: got %0d expected 1", q_count0); end
    early = 0;
    for (int i = 1; i <= 4; i++) begin
      step();
      if (if0.resp_valid !== 1'b0) early++;
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL fill_early_valid: got %0d early cycles expected 0", early); end
    step();                                   // edge t+5
    checks++; if (if0.resp_valid !== 1'b1) begin errors++; $display("FAIL fill_resp_valid: got %0h expected 1", if0.resp_valid); end
    checks++; if (if0.resp_we !== 1'b0) begin errors++; $display("FAIL fill_resp_we: got %0h expected 0", if0.resp_we); end
    checks++; if (if0.resp_addr !== 16'h1230) begin errors++; $display("FAIL fill_resp_addr: got %0h expected 1230", if0.resp_addr); end
    step();                                   // handshake edge
    checks++; if (nf0 !== 32'd1) begin errors++; $display("FAIL fill_num_fills: got %0d expected 1", nf0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL fill_busy: got %0h expected 0", busy0); end
    checks++; if (if0.resp_valid !== 1'b0) begin errors++; $display("FAIL fill_valid_drop: got %0h expected 0", if0.resp_valid); end
  endtask

  task automatic test_in_order();
    int c, early;
    do_reset();
    if0.resp_ready = 1'b1;
    if0.req_valid = 1'b1; if0.req_we = 1'b1; if0.req_addr = 16'h0040;
    step();                                   // writeback accepted at t
    if0.req_we = 1'b0;
    step();                                   // fill accepted at t+1
    if0.req_valid = 1'b0;
    c = 0;
    while (c < 20 && if0.resp_valid !== 1'b1) begin step(); c++; end
    checks++; if (c !== 4) begin errors++; $display("FAIL order_first_latency: got %0d cycles expected 4", c); end
    checks++; if (if0.resp_we !== 1'b1) begin errors++; $display("FAIL order_first_we: got %0h expected 1", if0.resp_we); end
    checks++; if (if0.resp_addr !== 16'h0040) begin errors++; $display("FAIL order_first_addr: got %0h expected 0040", if0.resp_addr); end
    step();                                   // handshake h
    checks++; if (nw0 !== 32'd1) begin errors++; $display("FAIL order_wb_count: got %0d expected 1", nw0); end
    early = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (if0.resp_valid !== 1'b0) early++;
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL order_gap: got %0d early cycles expected 0", early); end
    step();                                   // h+4
    checks++; if (if0.resp_valid !== 1'b1) begin errors++; $display("FAIL order_second_valid: got %0h expected 1", if0.resp_valid); end
    checks++; if (if0.resp_we !== 1'b0) begin errors++; $display("FAIL order_second_we: got %0h expected 0", if0.resp_we); end
    step();
    checks++; if (nf0 !== 32'd1) begin errors++; $display("FAIL order_num_fills: got %0d expected 1", nf0); end
    checks++; if (nw0 !== 32'd1) begin errors++; $display("FAIL order_num_writebacks: got %0d expected 1", nw0); end
  endtask

  task automatic test_backpressure();
    logic        in_we    [6];
    logic [15:0] in_addr  [6];
    logic [15:0] exp_addr [6];
    int idx, got;
    logic wp;
    in_addr  = '{16'h1005, 16'h2016, 16'h3027, 16'h4038, 16'h5049, 16'h605A};
    exp_addr = '{16'h1000, 16'h2010, 16'h3020, 16'h4030, 16'h5040, 16'h6050};
    in_we    = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    idx = 0;
    if0.req_valid = 1'b1; if0.req_we = in_we[0]; if0.req_addr = in_addr[0];
    repeat (12) begin
      wp = if0.req_valid && if0.req_ready;
      step();
      if (wp) begin
        idx++;
        if (idx < 6) begin if0.req_we = in_we[idx]; if0.req_addr = in_addr[idx]; end
        else if0.req_valid = 1'b0;
      end
    end
    checks++; if (idx !== 5) begin errors++; $display("FAIL bp_accepted: got %0d expected 5", idx); end
    checks++; if (q_count0 !== 3'd4) begin errors++; $display("FAIL bp_q_count_full: got %0d expected 4", q_count0); end
    checks++; if (if0.req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready: got %0h expected 0", if0.req_ready); end
    checks++; if (if0.resp_addr !== 16'h1000) begin errors++; $display("FAIL bp_head_addr: got %0h expected 1000", if0.resp_addr); end
    if0.resp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 100 && got < 6; c++) begin
      wp = if0.req_valid && if0.req_ready;
      if (if0.resp_valid === 1'b1) begin
        checks++; if (if0.resp_addr !== exp_addr[got]) begin errors++; $display("FAIL bp_order_addr[%0d]: got %0h expected %0h", got, if0.resp_addr, exp_addr[got]); end
        checks++; if (if0.resp_we !== in_we[got]) begin errors++; $display("FAIL bp_order_we[%0d]: got %0h expected %0h", got, if0.resp_we, in_we[got]); end
        got++;
      end
      step();
      if (wp) begin
        idx++;
        if (idx < 6) begin if0.req_we = in_we[idx]; if0.req_addr = in_addr[idx]; end
        else if0.req_valid = 1'b0;
      end
    end
    checks++; if (got !== 6) begin errors++; $display("FAIL bp_completions: got %0d expected 6", got); end
    checks++; if (nf0 !== 32'd3) begin errors++; $display("FAIL bp_num_fills: got %0d expected 3", nf0); end
    checks++; if (nw0 !== 32'd3) begin errors++; $display("FAIL bp_num_writebacks: got %0d expected 3", nw0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL bp_busy: got %0h expected 0", busy0); end
  endtask

  task automatic test_stall_hold();
    int c;
    do_reset();
    if0.req_valid = 1'b1; if0.req_we = 1'b1; if0.req_addr = 16'h0ABC;
    step();
    if0.req_valid = 1'b0;
    c = 0;
    while (c < 20 && if0.resp_valid !== 1'b1) begin step(); c++; end
    for (int i = 0; i < 10; i++) begin
      checks++; if (if0.resp_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %0h expected 1", i, if0.resp_valid); end
      checks++; if (if0.resp_we !== 1'b1) begin errors++; $display("FAIL stall_we[%0d]: got %0h expected 1", i, if0.resp_we); end
      checks++; if (if0.resp_addr !== 16'h0AB0) begin errors++; $display("FAIL stall_addr[%0d]: got %0h expected 0ab0", i, if0.resp_addr); end
      checks++; if (nw0 !== 32'd0) begin errors++; $display("FAIL stall_counter[%0d]: got %0d expected 0", i, nw0); end
      step();
    end
    if0.resp_ready = 1'b1;
    step();
    checks++; if (nw0 !== 32'd1) begin errors++; $display("FAIL stall_release_wb: got %0d expected 1", nw0); end
    checks++; if (if0.resp_valid !== 1'b0) begin errors++; $display("FAIL stall_release_valid: got %0h expected 0", if0.resp_valid); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] addrs [4];
    int stale;
    addrs = '{16'h0777, 16'h1111, 16'h2222, 16'h3333};
    do_reset();
    if0.resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if0.req_valid = 1'b1; if0.req_we = 1'b1; if0.req_addr = addrs[i];
      step();
    end
    if0.req_valid = 1'b0;
    checks++; if (q_count0 !== 3'd3) begin errors++; $display("FAIL mid_q_count: got %0d expected 3", q_count0); end
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL mid_busy: got %0h expected 1", busy0); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (if0.req_ready !== 1'b1) begin errors++; $display("FAIL mid_req_ready: got %0h expected 1", if0.req_ready); end
    checks++; if (if0.resp_valid !== 1'b0) begin errors++; $display("FAIL mid_resp_valid: got %0h expected 0", if0.resp_valid); end
    checks++; if (if0.resp_we !== 1'b0) begin errors++; $display("FAIL mid_resp_we: got %0h expected 0", if0.resp_we); end
    checks++; if (if0.resp_addr !== 16'h0000) begin errors++; $display("FAIL mid_resp_addr: got %0h expected 0", if0.resp_addr); end
    checks++; if (q_count0 !== 3'd0) begin errors++; $display("FAIL mid_q_count_clr: got %0d expected 0", q_count0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL mid_busy_clr: got %0h expected 0", busy0); end
    stale = 0;
    repeat (20) begin
      step();
      if (if0.resp_valid !== 1'b0 || q_count0 !== 3'd0) stale++;
    end
    checks++; if (stale !== 0) begin errors++; $display("FAIL mid_stale: got %0d stale cycles expected 0", stale); end
    checks++; if (nw0 !== 32'd0) begin errors++; $display("FAIL mid_num_writebacks: got %0d expected 0", nw0); end
  endtask

  task automatic test_latency_sweep();
    logic [15:0] exp_addr [3];
    logic        exp_we   [3];
    int got;
    exp_addr = '{16'h1230, 16'h2000, 16'h30F0};
    exp_we   = '{1'b0, 1'b1, 1'b0};
    do_reset();
    if1.req_valid = 1'b1; if1.req_we = 1'b0; if1.req_addr = 16'h1234;
    step();                                   // A accepted at t
    checks++; if (q_count1 !== 2'd1) begin errors++; $display("FAIL sweep_q_count_a: got %0d expected 1", q_count1); end
    if1.req_we = 1'b1; if1.req_addr = 16'h2001;
    step();                                   // t+1: pop A, push B
    checks++; if (if1.resp_valid !== 1'b0) begin errors++; $display("FAIL sweep_early_valid: got %0h expected 0", if1.resp_valid); end
    checks++; if (q_count1 !== 2'd1) begin errors++; $display("FAIL sweep_q_count_b: got %0d expected 1", q_count1); end
    if1.req_we = 1'b0; if1.req_addr = 16'h30FF;
    step();                                   // t+2: A in RESP, push C
    checks++; if (if1.resp_valid !== 1'b1) begin errors++; $display("FAIL sweep_resp_valid: got %0h expected 1", if1.resp_valid); end
    checks++; if (if1.resp_addr !== 16'h1230) begin errors++; $display("FAIL sweep_resp_addr: got %0h expected 1230", if1.resp_addr); end
    checks++; if (q_count1 !== 2'd2) begin errors++; $display("FAIL sweep_q_count_full: got %0d expected 2", q_count1); end
    checks++; if (if1.req_ready !== 1'b0) begin errors++; $display("FAIL sweep_req_ready: got %0h expected 0", if1.req_ready); end
    if1.req_we = 1'b1; if1.req_addr = 16'h4444;
    step();                                   // D refused
    checks++; if (q_count1 !== 2'd2) begin errors++; $display("FAIL sweep_refused: got %0d expected 2", q_count1); end
    if1.req_valid = 1'b0;
    if1.resp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 30 && got < 3; c++) begin
      if (if1.resp_valid === 1'b1) begin
        checks++; if (if1.resp_addr !== exp_addr[got] || if1.resp_we !== exp_we[got]) begin
          errors++; $display("FAIL sweep_order[%0d]: got %0h/%0h expected %0h/%0h", got, if1.resp_we, if1.resp_addr, exp_we[got], exp_addr[got]);
        end
        got++;
      end
      step();
    end
    checks++; if (got !== 3) begin errors++; $display("FAIL sweep_completions: got %0d expected 3", got); end
    checks++; if (nf1 !== 32'd2) begin errors++; $display("FAIL sweep_num_fills: got %0d expected 2", nf1); end
    checks++; if (nw1 !== 32'd1) begin errors++; $display("FAIL sweep_num_writebacks: got %0d expected 1", nw1); end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_single_fill();
    test_in_order();
    test_backpressure();
    test_stall_hold();
    test_reset_mid();
    test_latency_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Next-level memory model on the miss side of the cache simulator. It accepts line-fill requests (read misses) and writeback requests (dirty evictions) from the cache over a valid/ready request channel. Requests are buffered in an in-order FIFO and each is serviced after a fixed latency. Every request produces one completion on a valid/ready response channel. Line data is not modelled: only the line address, the request type and statistics are tracked, matching the tag-only cache model.

## Interface
- `ADDRESS_SIZE`, default 16: width of byte addresses.
- `LINESIZE`, default 128: line size in bits. Byte-select width is `BS = $clog2(LINESIZE>>3)`.
- `LATENCY`, default 4: service cycles per request. Must be ≥ 1.
- `QDEPTH`, default 4: request FIFO depth. Must be a power of 2 and ≥ 2.

Ports:
- `clk` in, 1: single clock. All logic is on the rising edge.
- `reset` in, 1: synchronous, active-high reset.
- `req_valid` in, 1: request present.
- `req_ready` out, 1: FIFO can accept.
- `req_we` in, 1: 1 = writeback, 0 = fill.
- `req_addr` in, ADDRESS_SIZE: line address. Low BS bits are ignored.
- `resp_valid` out, 1: completion present.
- `resp_ready` in, 1: cache accepts the completion.
- `resp_we` out, 1: type of the completed request.
- `resp_addr` out, ADDRESS_SIZE: completed line address with low BS bits forced to 0.
- `q_count` out, $clog2(QDEPTH)+1: FIFO occupancy.
- `num_fills` out, 32: completed fills.
- `num_writebacks` out, 32: completed writebacks.
- `busy` out, 1: high when the FSM is not IDLE or q_count ≠ 0.

## Operation
- **Elaboration check:** `$fatal` if `LATENCY` < 1, `QDEPTH` is not a power of 2, or `QDEPTH` < 2.
- **Request channel:**
  - `req_ready` = (q_count ≠ QDEPTH). It depends only on registered occupancy; there is no full-FIFO bypass.
  - A push occurs on the edge where `req_valid` && `req_ready`.
  - `{req_we, aligned addr}` is written at the tail.
- **FSM:**
  - **IDLE:** if q_count ≠ 0, pop the head into the service register, load `cnt` = LATENCY−1, and go to WAIT.
  - **WAIT:** if `cnt` = 0, go to RESP; otherwise decrement `cnt`.
  - **RESP:** `resp_valid` = 1, with `resp_we`/`resp_addr` taken from the service register and held stable until the handshake. On `resp_valid` && `resp_ready`:
    - increment `num_fills` (resp_we = 0) or `num_writebacks` (resp_we = 1);
    - if q_count ≠ 0, pop the next head, load `cnt` = LATENCY−1 and go to WAIT;
    - otherwise go to IDLE.
- **Ordering:** completions are strictly in acceptance order. A fill that follows a writeback to the same line completes after it; no reordering or merging.
- **Simultaneous push and pop:** on the same edge, q_count is unchanged. If the FIFO is full, the push is still refused because `req_ready` was 0.
- **Wrap-around:** FIFO pointers wrap modulo QDEPTH. Statistic counters wrap modulo 2^32.
- **Reset:** returns the FSM to IDLE, empties the FIFO and clears `cnt`. Reset dominates any concurrent handshake.

## Timing
- **Reset values:** `req_ready` = 1, `resp_valid` = 0, `resp_we` = 0, `resp_addr` = 0, `q_count` = 0, `num_fills` = 0, `num_writebacks` = 0, `busy` = 0.
- **Idle latency:** if a request is accepted at edge t while the FSM is IDLE with an empty FIFO:
  - the pop happens at t+1;
  - `resp_valid` rises after edge t+1+LATENCY, i.e. LATENCY+1 edges after acceptance.
- **Back-to-back completions:** after a response handshake at edge h with a non-empty FIFO, the next `resp_valid` rises after edge h+LATENCY. `resp_valid` drops for LATENCY cycles between completions.
- **Response stall:** while `resp_ready` = 0, `resp_valid`, `resp_we` and `resp_addr` are held. The FIFO keeps accepting requests until full.
- **Occupancy timing:** `q_count` updates one edge after a push or pop. `req_ready` reflects the registered `q_count`.
- **Registered outputs:** all outputs except `busy` are driven directly from registers. `busy` is combinational from registered state.

## Test plan
- **Single fill:** reset, then push fill `req_addr` = 0x1234 (LINESIZE = 128, so BS = 4). Required: `resp_valid` 5 edges later with `resp_we` = 0 and `resp_addr` = 0x1230. Handshake with `resp_ready` = 1; then `num_fills` = 1 and `busy` = 0 one cycle later.
- **In-order mix:** push writeback 0x0040 then fill 0x0040 on consecutive cycles, `resp_ready` tied 1. Required: the writeback completes first, the fill follows 4 edges after the first handshake, and the final counters are `num_writebacks` = 1, `num_fills` = 1.
- **Backpressure:** hold `resp_ready` = 0 and push 6 requests. Required:
  - the FSM pops 1, then 4 fill the FIFO (q_count = 4), `req_ready` = 0 and the 6th stalls;
  - after releasing `resp_ready`, all 6 complete in order with no loss or duplication.
- **Response stall hold:** `resp_ready` = 0 for 10 cycles during RESP. Required: `resp_valid`, `resp_we` and `resp_addr` stay constant and the counters do not change until the handshake.
- **Reset mid-operation:** with 3 queued and one in WAIT, assert `reset` for 1 cycle. Required: all outputs return to their reset values on the next edge, and no stale response appears afterwards.
- **Latency sweep:** repeat the single-fill test with LATENCY = 1 and QDEPTH = 2. Required: `resp_valid` 2 edges after acceptance, and `req_ready` drops when q_count = 2.
